food_placer: RTL and testbench
==============================

// Module: food_placer
// PURPOSE
//   Sequences the free-running random_food generator to place one food item.
//   On request it samples rand_x/rand_y, snaps the sample to the cell grid and bounds-checks it.
//   It then queries the snake-body checker and retries until it finds a free cell or exhausts its tries.
//   Sits between random_food, snake body storage and the VGA/game logic, which read food_x/food_y.
// PARAMETERS
//   CELL_LOG2   3     cell size = 2**CELL_LOG2 pixels; low coordinate bits cleared when snapping
//   X_MIN       16    lowest legal snapped x (inclusive)
//   X_MAX       616   highest legal snapped x (inclusive)
//   Y_MIN       16    lowest legal snapped y (inclusive)
//   Y_MAX       456   highest legal snapped y (inclusive)
//   MAX_TRIES   15    sample attempts before fallback; 4-bit counter
//   INIT_X      320   reset/fallback x (on grid)
//   INIT_Y      240   reset/fallback y (on grid)
// PORTS
//   clk          in   1   system clock
//   rst          in   1   asynchronous, active-low reset
//   place_req    in   1   1-cycle pulse: place new food (game start / food eaten)
//   rand_x       in   10  random x from random_food, new value every cycle
//   rand_y       in   9   random y from random_food
//   qry_valid    out  1   query strobe to body checker, 1 cycle
//   qry_x        out  10  cell x queried, held stable until qry_done
//   qry_y        out  9   cell y queried, held stable until qry_done
//   qry_done     in   1   checker finished (any latency >= 1 cycle after qry_valid)
//   qry_hit      in   1   cell occupied; sampled only when qry_done=1
//   food_x       out  10  current food x
//   food_y       out  9   current food y
//   food_valid   out  1   food position valid
//   busy         out  1   placement in progress (state != IDLE)
//   place_done   out  1   1-cycle pulse when food_x/food_y update
//   place_fail   out  1   sticky; set when fallback used, cleared on next place_req
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, food_x=INIT_X, food_y=INIT_Y, food_valid=0, busy=0,
//     qry_valid=0, qry_x=0, qry_y=0, place_done=0, place_fail=0, pending=0, tries=0.
//     Reset mid-placement aborts with no place_done.
//   FSM: IDLE -> SAMPLE -> CHECK -> QUERY -> WAIT -> COMMIT -> IDLE.
//   IDLE: place_req -> SAMPLE, tries=0, place_fail=0, food_valid=0.
//   SAMPLE: register sx={rand_x[9:CELL_LOG2],0s}, sy={rand_y[8:CELL_LOG2],0s}; tries+=1.
//   CHECK: in bounds (X_MIN<=sx<=X_MAX and Y_MIN<=sy<=Y_MAX) -> QUERY.
//     Out of bounds -> SAMPLE, or -> COMMIT with fallback if tries==MAX_TRIES.
//   QUERY: qry_valid=1 for exactly one cycle; qry_x=sx, qry_y=sy -> WAIT.
//   WAIT: hold qry_x/qry_y. On qry_done & !qry_hit -> COMMIT(sx,sy).
//     On qry_done & qry_hit -> SAMPLE, or -> COMMIT fallback if tries==MAX_TRIES.
//     qry_hit without qry_done is ignored.
//   COMMIT: food_x/food_y <= chosen values; food_valid=1; place_done=1 for 1 cycle.
//     Fallback = (INIT_X, INIT_Y) and sets place_fail; it is not re-queried.
//   place_req while busy: sets pending (no queue depth beyond 1). A pending request
//     starts a new placement the cycle after COMMIT; place_req in COMMIT also sets pending.
//   Latency: a free first sample takes 4 cycles + checker latency from req to place_done.
//   Comparisons are unsigned on full widths; snapping never overflows.
// STRUCTURE
//   Shared package/include (snake_defs): CELL_LOG2, playfield X/Y bounds, INIT_X/INIT_Y,
//     coordinate widths (10/9), FSM state encodings.
//   Single module. Snap/bounds logic is combinational inside; no sub-module needed.
// TESTING
//   1 Reset: rst=0 -> food=(320,240), food_valid=0, busy=0; release, idle for 20 cycles, no qry_valid.
//   2 Free cell: force rand=(100,200), checker done next cycle with hit=0 -> qry=(96,200), food=(96,200).
//     place_done exactly once, food_valid=1.
//   3 Retry: rand (8,8) out of bounds, then (40,40) hit, then (64,72) free -> one query for (40,40),
//     one for (64,72); food=(64,72); tries=3.
//   4 Exhaustion: every query hit=1 -> 15 samples, then food=(320,240), place_fail=1.
//     Next place_req clears place_fail.
//   5 Pending: place_req during WAIT -> 2nd placement starts the cycle after COMMIT; two place_done pulses total.
//   6 Async reset mid-WAIT: rst low between clock edges -> outputs at reset values immediately, no place_done.

Source files
------------

// File: rtl/food_placer_pkg.sv
// ---------------------------------------------------------------------------
// food_placer_pkg
//   Shared definitions for the food placement logic:
//   - coordinate widths of the VGA playfield (x: 10 bits, y: 9 bits)
//   - default cell size, playfield bounds and reset/fallback position
//   - retry budget and FSM state encoding
// ---------------------------------------------------------------------------
package food_placer_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int TRIES_W = 4;

    localparam int DEF_CELL_LOG2 = 3;
    localparam int DEF_X_MIN     = 16;
    localparam int DEF_X_MAX     = 616;
    localparam int DEF_Y_MIN     = 16;
    localparam int DEF_Y_MAX     = 456;
    localparam int DEF_MAX_TRIES = 15;
    localparam int DEF_INIT_X    = 320;
    localparam int DEF_INIT_Y    = 240;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_QUERY  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_COMMIT = 3'd5
    } state_e;

endpackage : food_placer_pkg

// File: rtl/food_placer.sv
// ---------------------------------------------------------------------------
// food_placer
//   Places one food item on request. Samples the free-running random
//   coordinates, snaps them to the cell grid, bounds-checks them, asks the
//   snake-body checker whether the cell is free and retries until a free
//   cell is found or the try budget runs out (then falls back to INIT_X/Y).
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   place_req   in   1-cycle request pulse (game start / food eaten)
//   rand_x      in   [9:0] random x, changes every cycle
//   rand_y      in   [8:0] random y
//   qry_valid   out  1-cycle query strobe to the body checker
//   qry_x       out  [9:0] queried cell x, stable until qry_done
//   qry_y       out  [8:0] queried cell y, stable until qry_done
//   qry_done    in   checker finished
//   qry_hit     in   cell occupied (meaningful only with qry_done)
//   food_x      out  [9:0] current food x
//   food_y      out  [8:0] current food y
//   food_valid  out  food position valid
//   busy        out  placement in progress
//   place_done  out  1-cycle pulse when food_x/food_y update
//   place_fail  out  sticky fallback flag, cleared by the next placement
// ---------------------------------------------------------------------------
module food_placer
    import food_placer_pkg::*;
#(
    parameter int CELL_LOG2 = DEF_CELL_LOG2,
    parameter int X_MIN     = DEF_X_MIN,
    parameter int X_MAX     = DEF_X_MAX,
    parameter int Y_MIN     = DEF_Y_MIN,
    parameter int Y_MAX     = DEF_Y_MAX,
    parameter int MAX_TRIES = DEF_MAX_TRIES,
    parameter int INIT_X    = DEF_INIT_X,
    parameter int INIT_Y    = DEF_INIT_Y
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           place_req,
    input  logic [X_W-1:0] rand_x,
    input  logic [Y_W-1:0] rand_y,
    output logic           qry_valid,
    output logic [X_W-1:0] qry_x,
    output logic [Y_W-1:0] qry_y,
    input  logic           qry_done,
    input  logic           qry_hit,
    output logic [X_W-1:0] food_x,
    output logic [Y_W-1:0] food_y,
    output logic           food_valid,
    output logic           busy,
    output logic           place_done,
    output logic           place_fail
);

    // Sized constants so every comparison is done unsigned at the port width.
    localparam logic [X_W-1:0]     X_MASK     = ~X_W'((1 << CELL_LOG2) - 1);
    localparam logic [Y_W-1:0]     Y_MASK     = ~Y_W'((1 << CELL_LOG2) - 1);
    localparam logic [X_W-1:0]     X_LO       = X_W'(X_MIN);
    localparam logic [X_W-1:0]     X_HI       = X_W'(X_MAX);
    localparam logic [Y_W-1:0]     Y_LO       = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0]     Y_HI       = Y_W'(Y_MAX);
    localparam logic [X_W-1:0]     FALLBACK_X = X_W'(INIT_X);
    localparam logic [Y_W-1:0]     FALLBACK_Y = Y_W'(INIT_Y);
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES);

    state_e               state_q;
    logic [X_W-1:0]       sx_q;
    logic [Y_W-1:0]       sy_q;
    logic [TRIES_W-1:0]   tries_q;
    logic                 pending_q;
    logic                 qry_valid_q;
    logic [X_W-1:0]       qry_x_q;
    logic [Y_W-1:0]       qry_y_q;
    logic [X_W-1:0]       food_x_q;
    logic [Y_W-1:0]       food_y_q;
    logic                 food_valid_q;
    logic                 busy_q;
    logic                 place_done_q;
    logic                 place_fail_q;

    // Snapping only clears low bits, so it can never overflow.
    logic [X_W-1:0] sx_d;
    logic [Y_W-1:0] sy_d;
    logic           in_bounds;
    logic           out_of_tries;

    always_comb begin
        sx_d         = rand_x & X_MASK;
        sy_d         = rand_y & Y_MASK;
        in_bounds    = (sx_q >= X_LO) && (sx_q <= X_HI) &&
                       (sy_q >= Y_LO) && (sy_q <= Y_HI);
        out_of_tries = (tries_q == TRIES_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            sx_q         <= '0;
            sy_q         <= '0;
            tries_q      <= '0;
            pending_q    <= 1'b0;
            qry_valid_q  <= 1'b0;
            qry_x_q      <= '0;
            qry_y_q      <= '0;
            food_x_q     <= FALLBACK_X;
            food_y_q     <= FALLBACK_Y;
            food_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            place_done_q <= 1'b0;
            place_fail_q <= 1'b0;
        end else begin
            qry_valid_q  <= 1'b0;
            place_done_q <= 1'b0;

            // A request arriving mid-placement is remembered (depth 1).
            // COMMIT consumes place_req directly, so it is excluded here.
            if (place_req && (state_q != ST_IDLE) && (state_q != ST_COMMIT)) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (place_req) begin
                        state_q      <= ST_SAMPLE;
                        tries_q      <= '0;
                        place_fail_q <= 1'b0;
                        food_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    sx_q    <= sx_d;
                    sy_q    <= sy_d;
                    tries_q <= tries_q + 1'b1;
                    state_q <= ST_CHECK;
                end

                ST_CHECK: begin
                    if (in_bounds) begin
                        qry_valid_q <= 1'b1;
                        qry_x_q     <= sx_q;
                        qry_y_q     <= sy_q;
                        state_q     <= ST_QUERY;
                    end else if (out_of_tries) begin
                        food_x_q     <= FALLBACK_X;
                        food_y_q     <= FALLBACK_Y;
                        food_valid_q <= 1'b1;
                        place_done_q <= 1'b1;
                        place_fail_q <= 1'b1;
                        state_q      <= ST_COMMIT;
                    end else begin
                        state_q <= ST_SAMPLE;
                    end
                end

                ST_QUERY: begin
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    // qry_hit is only meaningful alongside qry_done.
                    if (qry_done) begin
                        if (!qry_hit) begin
                            food_x_q     <= sx_q;
                            food_y_q     <= sy_q;
                            food_valid_q <= 1'b1;
                            place_done_q <= 1'b1;
                            state_q      <= ST_COMMIT;
                        end else if (out_of_tries) begin
                            food_x_q     <= FALLBACK_X;
                            food_y_q     <= FALLBACK_Y;
                            food_valid_q <= 1'b1;
                            place_done_q <= 1'b1;
                            place_fail_q <= 1'b1;
                            state_q      <= ST_COMMIT;
                        end else begin
                            state_q <= ST_SAMPLE;
                        end
                    end
                end

                ST_COMMIT: begin
                    // Chain straight into the next placement if one is waiting.
                    if (pending_q || place_req) begin
                        pending_q    <= 1'b0;
                        state_q      <= ST_SAMPLE;
                        tries_q      <= '0;
                        place_fail_q <= 1'b0;
                        food_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign qry_valid  = qry_valid_q;
    assign qry_x      = qry_x_q;
    assign qry_y      = qry_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign busy       = busy_q;
    assign place_done = place_done_q;
    assign place_fail = place_fail_q;

endmodule : food_placer

// File: tb/tb_food_placer.sv
// ---------------------------------------------------------------------------
// tb_food_placer
//   Directed bench for food_placer. A behavioural body checker answers each
//   query after a programmable delay with a scripted hit pattern and logs the
//   queried coordinates. Each scenario task drives its stimulus and compares
//   against hand-computed values.
// ---------------------------------------------------------------------------
module tb_food_placer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       place_req = 1'b0;
    logic [9:0] rand_x = '0;
    logic [8:0] rand_y = '0;
    logic       qry_valid;
    logic [9:0] qry_x;
    logic [8:0] qry_y;
    logic       qry_done = 1'b0;
    logic       qry_hit = 1'b0;
    logic [9:0] food_x;
    logic [8:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       place_done;
    logic       place_fail;

    int checks   = 0;
    int failures = 0;

    food_placer dut (
        .clk        (clk),
        .rst        (rst),
        .place_req  (place_req),
        .rand_x     (rand_x),
        .rand_y     (rand_y),
        .qry_valid  (qry_valid),
        .qry_x      (qry_x),
        .qry_y      (qry_y),
        .qry_done   (qry_done),
        .qry_hit    (qry_hit),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .busy       (busy),
        .place_done (place_done),
        .place_fail (place_fail)
    );

    always #5 clk = ~clk;

    // ---------------- body checker model ----------------
    int          resp_delay = 1;     // cycles from qry_valid to qry_done
    logic [31:0] hit_mask   = '0;    // bit i: i-th query (from hit_base) is a hit
    int          hit_base   = 0;
    logic        stray_hit  = 1'b0;  // drive qry_hit while waiting, without qry_done
    int          qcount     = 0;
    logic [9:0]  qlog_x [0:31];
    logic [8:0]  qlog_y [0:31];
    int          pend       = 0;
    logic        pend_hit   = 1'b0;
    int          done_count = 0;

    always @(negedge clk) begin
        qry_done = 1'b0;
        qry_hit  = 1'b0;
        if (!rst) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    qry_done = 1'b1;
                    qry_hit  = pend_hit;
                end else begin
                    qry_hit = stray_hit;
                end
            end
            if (qry_valid) begin
                if (qcount - hit_base < 32) begin
                    qlog_x[qcount - hit_base] = qry_x;
                    qlog_y[qcount - hit_base] = qry_y;
                    pend_hit = hit_mask[qcount - hit_base];
                end
                pend   = resp_delay;
                qcount = qcount + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (place_done) done_count = done_count + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_req();
        @(negedge clk);
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
    endtask

    // Returns the negedge index (1 = first negedge after the request edge)
    // at which place_done is seen; 0 on timeout.
    task automatic wait_place_done(input int max, output int cyc);
        int n;
        n = 1;
        while (!place_done && n < max) begin
            @(negedge clk);
            n++;
        end
        cyc = place_done ? n : 0;
    endtask

    task automatic wait_qry_valid(input int max, output bit ok);
        int n;
        n = 0;
        while (!qry_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        ok = qry_valid;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int qv_seen;
        #1 rst = 1'b0;
        #2;
        checks++; if (food_x !== 10'd320) begin failures++; $display("FAIL reset_food_x: got %0d expected 320", food_x); end
        checks++; if (food_y !== 9'd240) begin failures++; $display("FAIL reset_food_y: got %0d expected 240", food_y); end
        checks++; if (food_valid !== 1'b0) begin failures++; $display("FAIL reset_food_valid: got %b expected 0", food_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({qry_valid, place_done, place_fail} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {qry_valid, place_done, place_fail}); end
        checks++; if ({qry_x, qry_y} !== 19'd0) begin failures++; $display("FAIL reset_qry_xy: got %0d/%0d expected 0/0", qry_x, qry_y); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        qv_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (qry_valid || busy) qv_seen++;
        end
        checks++; if (qv_seen !== 0) begin failures++; $display("FAIL idle_activity: got %0d active cycles expected 0", qv_seen); end
        $display("reset: food=(%0d,%0d) valid=%b busy=%b", food_x, food_y, food_valid, busy);
    endtask

    task automatic test_free_cell();
        int cyc;
        int d0;
        resp_delay = 1; stray_hit = 1'b0; hit_mask = '0; hit_base = qcount;
        rand_x = 10'd100; rand_y = 9'd200;
        d0 = done_count;
        pulse_req();
        wait_place_done(100, cyc);
        checks++; if (cyc !== 5) begin failures++; $display("FAIL free_latency: got %0d expected 5", cyc); end
        checks++; if (qcount - hit_base !== 1) begin failures++; $display("FAIL free_queries: got %0d expected 1", qcount - hit_base); end
        checks++; if (qlog_x[0] !== 10'd96 || qlog_y[0] !== 9'd200) begin failures++; $display("FAIL free_qry_xy: got (%0d,%0d) expected (96,200)", qlog_x[0], qlog_y[0]); end
        checks++; if (food_x !== 10'd96 || food_y !== 9'd200) begin failures++; $display("FAIL free_food: got (%0d,%0d) expected (96,200)", food_x, food_y); end
        checks++; if (food_valid !== 1'b1) begin failures++; $display("FAIL free_food_valid: got %b expected 1", food_valid); end
        repeat (3) @(negedge clk);
        checks++; if (done_count - d0 !== 1) begin failures++; $display("FAIL free_done_pulses: got %0d expected 1", done_count - d0); end
        checks++; if (busy !== 1'b0 || food_valid !== 1'b1) begin failures++; $display("FAIL free_idle: got busy=%b valid=%b expected busy=0 valid=1", busy, food_valid); end
        $display("free_cell: food=(%0d,%0d) latency=%0d", food_x, food_y, cyc);
    endtask

    task automatic test_retry();
        int cyc;
        bit ok;
        resp_delay = 1; stray_hit = 1'b0; hit_mask = 32'h1; hit_base = qcount;
        rand_x = 10'd8; rand_y = 9'd8;
        pulse_req();
        @(negedge clk);                   // (8,8) sampled at the edge before this
        rand_x = 10'd40; rand_y = 9'd40;
        wait_qry_valid(50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL retry_first_query: got timeout expected qry_valid"); end
        rand_x = 10'd64; rand_y = 9'd72;
        wait_place_done(100, cyc);
        checks++; if (cyc == 0) begin failures++; $display("FAIL retry_done: got timeout expected place_done"); end
        checks++; if (qcount - hit_base !== 2) begin failures++; $display("FAIL retry_queries: got %0d expected 2", qcount - hit_base); end
        checks++; if (qlog_x[0] !== 10'd40 || qlog_y[0] !== 9'd40) begin failures++; $display("FAIL retry_qry0: got (%0d,%0d) expected (40,40)", qlog_x[0], qlog_y[0]); end
        checks++; if (qlog_x[1] !== 10'd64 || qlog_y[1] !== 9'd72) begin failures++; $display("FAIL retry_qry1: got (%0d,%0d) expected (64,72)", qlog_x[1], qlog_y[1]); end
        checks++; if (food_x !== 10'd64 || food_y !== 9'd72) begin failures++; $display("FAIL retry_food: got (%0d,%0d) expected (64,72)", food_x, food_y); end
        checks++; if (dut.tries_q !== 4'd3) begin failures++; $display("FAIL retry_tries: got %0d expected 3", dut.tries_q); end
        checks++; if (place_fail !== 1'b0) begin failures++; $display("FAIL retry_place_fail: got %b expected 0", place_fail); end
        @(negedge clk);
        $display("retry: food=(%0d,%0d) queries=%0d", food_x, food_y, qcount - hit_base);
    endtask

    task automatic test_exhaustion();
        int cyc;
        resp_delay = 1; stray_hit = 1'b0; hit_mask = 32'hFFFF_FFFF; hit_base = qcount;
        rand_x = 10'd100; rand_y = 9'd200;
        pulse_req();
        wait_place_done(400, cyc);
        checks++; if (cyc == 0) begin failures++; $display("FAIL exhaust_done: got timeout expected place_done"); end
        checks++; if (qcount - hit_base !== 15) begin failures++; $display("FAIL exhaust_queries: got %0d expected 15", qcount - hit_base); end
        checks++; if (food_x !== 10'd320 || food_y !== 9'd240) begin failures++; $display("FAIL exhaust_food: got (%0d,%0d) expected (320,240)", food_x, food_y); end
        checks++; if (place_fail !== 1'b1 || food_valid !== 1'b1) begin failures++; $display("FAIL exhaust_flags: got fail=%b valid=%b expected 1/1", place_fail, food_valid); end
        repeat (3) @(negedge clk);
        checks++; if (place_fail !== 1'b1) begin failures++; $display("FAIL exhaust_sticky: got %b expected 1", place_fail); end
        $display("exhaustion: food=(%0d,%0d) fail=%b", food_x, food_y, place_fail);
        hit_mask = '0; hit_base = qcount;
        pulse_req();
        checks++; if (place_fail !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL exhaust_clear: got fail=%b busy=%b expected 0/1", place_fail, busy); end
        wait_place_done(100, cyc);
        checks++; if (food_x !== 10'd96 || food_y !== 9'd200 || place_fail !== 1'b0) begin failures++; $display("FAIL exhaust_recover: got (%0d,%0d) fail=%b expected (96,200) fail=0", food_x, food_y, place_fail); end
        @(negedge clk);
        $display("recover: food=(%0d,%0d) fail=%b", food_x, food_y, place_fail);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int d0;
        bit ok;
        resp_delay = 3; stray_hit = 1'b1; hit_mask = '0; hit_base = qcount;
        rand_x = 10'd200; rand_y = 9'd100;
        d0 = done_count;
        pulse_req();
        wait_qry_valid(50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL pend_query: got timeout expected qry_valid"); end
        @(negedge clk);                   // now in WAIT
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        wait_place_done(100, cyc);
        checks++; if (food_x !== 10'd200 || food_y !== 9'd96) begin failures++; $display("FAIL pend_food1: got (%0d,%0d) expected (200,96)", food_x, food_y); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || food_valid !== 1'b0 || place_done !== 1'b0) begin failures++; $display("FAIL pend_restart: got busy=%b valid=%b done=%b expected 1/0/0", busy, food_valid, place_done); end
        wait_place_done(100, cyc);
        checks++; if (cyc == 0) begin failures++; $display("FAIL pend_done2: got timeout expected place_done"); end
        repeat (5) @(negedge clk);
        checks++; if (done_count - d0 !== 2) begin failures++; $display("FAIL pend_pulses: got %0d expected 2", done_count - d0); end
        checks++; if (qcount - hit_base !== 2) begin failures++; $display("FAIL pend_queries: got %0d expected 2", qcount - hit_base); end
        checks++; if (busy !== 1'b0 || food_valid !== 1'b1) begin failures++; $display("FAIL pend_idle: got busy=%b valid=%b expected 0/1", busy, food_valid); end
        stray_hit = 1'b0;
        $display("back_to_back: pulses=%0d food=(%0d,%0d)", done_count - d0, food_x, food_y);
    endtask

    task automatic test_async_reset();
        int d0;
        bit ok;
        resp_delay = 3; stray_hit = 1'b0; hit_mask = '0; hit_base = qcount;
        rand_x = 10'd400; rand_y = 9'd300;
        pulse_req();
        wait_qry_valid(50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL areset_query: got timeout expected qry_valid"); end
        @(negedge clk);                   // in WAIT, checker still pending
        d0 = done_count;
        #2 rst = 1'b0;
        #1;
        checks++; if (food_x !== 10'd320 || food_y !== 9'd240) begin failures++; $display("FAIL areset_food: got (%0d,%0d) expected (320,240)", food_x, food_y); end
        checks++; if ({food_valid, busy, qry_valid, place_done, place_fail} !== 5'b00000) begin failures++; $display("FAIL areset_flags: got %b expected 00000", {food_valid, busy, qry_valid, place_done, place_fail}); end
        checks++; if ({qry_x, qry_y} !== 19'd0) begin failures++; $display("FAIL areset_qry_xy: got %0d/%0d expected 0/0", qry_x, qry_y); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (done_count !== d0) begin failures++; $display("FAIL areset_no_done: got %0d pulses expected 0", done_count - d0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy: got %b expected 0", busy); end
        $display("async_reset: food=(%0d,%0d) busy=%b", food_x, food_y, busy);
    endtask

    initial begin
        test_reset();
        test_free_cell();
        test_retry();
        test_exhaustion();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_food_placer
